alu_operand_issue: RTL and testbench
====================================

# alu_operand_issue

Operand-issue stage directly upstream of the ALU. Holds the 8-entry architectural register file, reads two source operands per accepted instruction, optionally substitutes an immediate for operand B, and presents registered InputA/InputB/OP to the ALU behind a valid/ready handshake. The writeback path writes results back into the register file through a dedicated write port; same-cycle read-after-write is either bypassed or stalled depending on configuration.

## Interface
- DW, 16, data width; matches ALU InputA/InputB/Out
- NREG, 8, register count; address width AW = $clog2(NREG) = 3
- Clk  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  upstream instruction valid
- InReady  out  1  stage can accept this cycle
- InOp  in  3  ALU opcode, passed through to OP
- InSrcA  in  AW  register index for operand A
- InSrcB  in  AW  register index for operand B
- InUseImm  in  1  1: operand B = InImm, InSrcB ignored
- InImm  in  DW  immediate value
- WrEn  in  1  writeback write enable
- WrAddr  in  AW  writeback register index
- WrData  in  DW  writeback data
- Flush  in  1  discard held instruction, block accept this cycle
- OutValid  out  1  InputA/InputB/OP valid to ALU consumer
- OutReady  in  1  ALU consumer takes the held instruction
- InputA  out  DW  operand A to ALU
- InputB  out  DW  operand B to ALU
- OP  out  3  opcode to ALU

## Operation
- Register file: NREG x DW flops; register 0 reads as 0 always; writes to index 0 ignored.
- Write: WrEn=1 and WrAddr!=0 -> reg[WrAddr] <= WrData at the edge; independent of handshake, Flush, stalls.
- Output slot: single register stage holding {InputA, InputB, OP}, flagged by OutValid.
- Transfer out: OutValid && OutReady; slot empties unless refilled same cycle.
- InReady = !Flush && !Hazard && (!OutValid || OutReady).
- Accept: InValid && InReady -> slot loads next edge, OutValid <= 1.
  - InputA <= read(InSrcA); InputB <= InUseImm ? InImm : read(InSrcB); OP <= InOp.
- Simultaneous transfer out and accept: slot refilled, OutValid stays 1 (full throughput, one per cycle).
- Flush: OutValid <= 0 next edge regardless of OutReady; no accept that cycle; register file writes still occur. Data outputs keep stale values (don't-care while OutValid=0).
- Held slot: while OutValid && !OutReady, InputA/InputB/OP must remain stable; later register writes do not alter held operands.
- Hazard: defined under Configuration; always 0 when FORWARD_EN is defined.
- Reset (asserted any time, including mid-transfer): OutValid=0, InputA=0, InputB=0, OP=0, all registers 0; InReady=1 once Reset_n high (combinational, may read 1 during reset is not relied on).

## Timing
- Latency: accept edge N -> operands visible on InputA/InputB with OutValid=1 after edge N.
- Write-to-read: write at edge N visible to a read accepted at cycle N+1 in all configurations.
- InReady purely combinational from Flush, OutValid, OutReady, hazard inputs; no combinational path from InValid to InReady.
- OutValid, InputA, InputB, OP driven only from flops.

## Configuration
- FORWARD_EN defined: same-cycle bypass. If WrEn && WrAddr!=0 && WrAddr matches a source being read in the accept cycle, the read returns WrData. Hazard=0.
- FORWARD_EN undefined: no bypass. Hazard = WrEn && WrAddr!=0 && (WrAddr==InSrcA || (!InUseImm && WrAddr==InSrcB)) while InValid; InReady drops for that cycle, instruction accepted next cycle with the written value.

## Test plan
- Reset then write reg3=0x0004, reg5=0x0001; issue OP=3'b101, SrcA=3, SrcB=5 with OutReady=1 -> next cycle OutValid=1, InputA=0x0004, InputB=0x0001, OP=3'b101.
- Write reg0=0xFFFF, issue SrcA=0, InUseImm=1, InImm=0x1234 -> InputA=0x0000, InputB=0x1234.
- OutReady=0 for 3 cycles with slot full, write new value to held source register -> InReady=0, outputs unchanged; OutReady=1 -> next instruction accepted same cycle, back-to-back one per cycle.
- Same-cycle WrEn WrAddr=2 WrData=0x00AA with issue SrcA=2 (old reg2=0x0011) -> FORWARD_EN: InputA=0x00AA after one edge; without: InReady=0 one cycle, then InputA=0x00AA one cycle later.
- Flush with OutValid=1, OutReady=0 and InValid=1 -> OutValid=0 next edge, no accept; WrEn in same cycle still lands.
- Assert Reset_n=0 mid-stream asynchronously (between edges) -> OutValid, InputA, InputB, OP immediately 0; reads of every register return 0 after release.

Source files
------------

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: register file read and operand slot feeding the ALU.
// Define FORWARD_EN to bypass same-cycle writeback into reads instead of stalling.
module alu_operand_issue #(
    parameter int DW = 16,
    parameter int NREG = 8,
    localparam int AW = $clog2(NREG)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [2:0]    InOp,
    input  logic [AW-1:0] InSrcA,
    input  logic [AW-1:0] InSrcB,
    input  logic          InUseImm,
    input  logic [DW-1:0] InImm,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    input  logic          Flush,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] InputA,
    output logic [DW-1:0] InputB,
    output logic [2:0]    OP
);
    logic [DW-1:0] rf_q [NREG];
    logic          valid_q, valid_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          we, hazard, accept;

    assign we = WrEn && WrAddr != '0;

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] idx);
`ifdef FORWARD_EN
        if (we && WrAddr == idx) return WrData;
`endif
        return idx == '0 ? '0 : rf_q[idx];
    endfunction

`ifdef FORWARD_EN
    assign hazard = 1'b0;
`else
    // Qualified by InValid only through accept, keeping InValid off the InReady path
    assign hazard = we && (WrAddr == InSrcA || (!InUseImm && WrAddr == InSrcB));
`endif

    assign InReady = !Flush && !hazard && (!valid_q || OutReady);
    assign accept  = InValid && InReady;

    always_comb begin
        valid_d = Flush ? 1'b0 : accept ? 1'b1 : valid_q && !OutReady;
        a_d     = accept ? rd(InSrcA) : a_q;
        b_d     = accept ? (InUseImm ? InImm : rd(InSrcB)) : b_q;
        op_d    = accept ? InOp : op_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            if (we) rf_q[WrAddr] <= WrData;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign OutValid = valid_q;
    assign InputA   = a_q;
    assign InputB   = b_q;
    assign OP       = op_q;
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: directed scenarios plus randomized traffic against a register-file model.
module tb_alu_operand_issue;
    logic        Clk = 0, Reset_n = 0;
    logic        InValid, InReady, InUseImm, WrEn, Flush, OutValid, OutReady;
    logic [2:0]  InOp, InSrcA, InSrcB, WrAddr, OP;
    logic [15:0] InImm, WrData, InputA, InputB;
    int checks = 0, errors = 0;

    alu_operand_issue dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady), .InOp(InOp),
        .InSrcA(InSrcA), .InSrcB(InSrcB), .InUseImm(InUseImm), .InImm(InImm), .WrEn(WrEn),
        .WrAddr(WrAddr), .WrData(WrData), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .InputA(InputA), .InputB(InputB), .OP(OP)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        InValid = 0; InOp = 0; InSrcA = 0; InSrcB = 0; InUseImm = 0; InImm = 0;
        WrEn = 0; WrAddr = 0; WrData = 0; Flush = 0; OutReady = 1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        WrEn = 1; WrAddr = a; WrData = d;
        tick();
        WrEn = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic imm, input logic [15:0] iv);
        InValid = 1; InOp = op; InSrcA = sa; InSrcB = sb; InUseImm = imm; InImm = iv;
    endtask

    task automatic test_reset();
        idle();
        Reset_n = 0;
        #1;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", OutValid); end
        checks++; if ({InputA, InputB, OP} !== 35'd0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", InputA, InputB, OP); end
        #20 Reset_n = 1;
        tick();
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", InReady); end
    endtask

    task automatic test_basic();
        write_reg(3, 16'h0004);
        write_reg(5, 16'h0001);
        issue(3'b101, 3, 5, 0, 0);
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", InReady); end
        tick();
        InValid = 0;
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", OutValid); end
        checks++; if ({InputA, InputB, OP} !== {16'h0004, 16'h0001, 3'b101}) begin errors++; $display("FAIL basic_data got %h/%h/%h exp 0004/0001/5", InputA, InputB, OP); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", OutValid); end
    endtask

    task automatic test_imm();
        write_reg(0, 16'hFFFF);
        issue(3'b010, 0, 7, 1, 16'h1234);
        tick();
        InValid = 0;
        checks++; if ({OutValid, InputA, InputB, OP} !== {1'b1, 16'h0000, 16'h1234, 3'b010}) begin errors++; $display("FAIL imm got %b/%h/%h/%h exp 1/0000/1234/2", OutValid, InputA, InputB, OP); end
    endtask

    task automatic test_hold();
        OutReady = 0;
        issue(3'b001, 3, 5, 0, 0);
        WrEn = 1; WrAddr = 3; WrData = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 0", i, InReady); end
            tick();
            WrEn = 0;
            checks++; if ({OutValid, InputA, InputB, OP} !== {1'b1, 16'h0000, 16'h1234, 3'b010}) begin errors++; $display("FAIL hold_data[%0d] got %b/%h/%h/%h exp 1/0000/1234/2", i, OutValid, InputA, InputB, OP); end
        end
        OutReady = 1;
        for (int i = 0; i < 4; i++) begin
            issue(3'(i + 1), i[0] ? 5 : 3, i[0] ? 3 : 5, 0, 0);
            #1;
            checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, InReady); end
            tick();
            checks++; if ({OutValid, InputA, InputB, OP} !== {1'b1, i[0] ? 16'h0001 : 16'h7777, i[0] ? 16'h7777 : 16'h0001, 3'(i + 1)})
                begin errors++; $display("FAIL b2b_data[%0d] got %b/%h/%h/%h", i, OutValid, InputA, InputB, OP); end
        end
        InValid = 0;
        tick();
    endtask

    task automatic test_raw();
        write_reg(2, 16'h0011);
        issue(3'b011, 2, 0, 1, 16'h0000);
        WrEn = 1; WrAddr = 2; WrData = 16'h00AA;
        #1;
`ifdef FORWARD_EN
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL raw_ready got %b exp 1", InReady); end
        tick();
        WrEn = 0; InValid = 0;
`else
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", InReady); end
        tick();
        WrEn = 0;
        #1;
        checks++; if ({InReady, OutValid} !== 2'b10) begin errors++; $display("FAIL raw_retry got %b%b exp 10", InReady, OutValid); end
        tick();
        InValid = 0;
`endif
        checks++; if ({OutValid, InputA} !== {1'b1, 16'h00AA}) begin errors++; $display("FAIL raw_data got %b/%h exp 1/00aa", OutValid, InputA); end
        tick();
    endtask

    task automatic test_flush();
        OutReady = 0;
        issue(3'b110, 5, 3, 0, 0);
        tick();
        Flush = 1;
        issue(3'b111, 3, 3, 0, 0);
        WrEn = 1; WrAddr = 6; WrData = 16'h0BEE;
        #1;
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", InReady); end
        tick();
        Flush = 0; WrEn = 0; InValid = 0;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", OutValid); end
        OutReady = 1;
        issue(3'b100, 6, 0, 1, 16'h0055);
        tick();
        InValid = 0;
        checks++; if ({OutValid, InputA, InputB} !== {1'b1, 16'h0BEE, 16'h0055}) begin errors++; $display("FAIL flush_write got %b/%h/%h exp 1/0bee/0055", OutValid, InputA, InputB); end
    endtask

    task automatic test_async_reset();
        OutReady = 0;
        issue(3'b101, 6, 5, 0, 0);
        tick();
        #2 Reset_n = 0;
        #1;
        checks++; if ({OutValid, InputA, InputB, OP} !== 36'd0) begin errors++; $display("FAIL areset got %b/%h/%h/%h exp 0", OutValid, InputA, InputB, OP); end
        #2 Reset_n = 1;
        idle();
        for (int r = 0; r < 8; r++) begin
            issue(3'b001, 3'(r), 3'(r), 0, 0);
            tick();
            checks++; if ({OutValid, InputA, InputB} !== {1'b1, 32'd0}) begin errors++; $display("FAIL areset_reg%0d got %b/%h/%h exp 1/0/0", r, OutValid, InputA, InputB); end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [15:0] m_rf [8];
        logic        m_v, rdy, haz, acc;
        logic [15:0] m_a, m_b, ra, rb;
        logic [2:0]  m_op;
        idle();
        #2 Reset_n = 0;
        #2 Reset_n = 1;
        for (int r = 0; r < 8; r++) m_rf[r] = 0;
        m_v = 0; m_a = 0; m_b = 0; m_op = 0;
        tick();
        for (int n = 0; n < 400; n++) begin
            InValid = $urandom_range(0, 3) != 0; InOp = 3'($urandom); InSrcA = 3'($urandom);
            InSrcB = 3'($urandom); InUseImm = $urandom_range(0, 3) == 0; InImm = 16'($urandom);
            WrEn = $urandom_range(0, 1) == 1; WrAddr = 3'($urandom); WrData = 16'($urandom);
            Flush = $urandom_range(0, 15) == 0; OutReady = $urandom_range(0, 2) != 0;
            ra = InSrcA == 0 ? 16'd0 : m_rf[InSrcA];
            rb = InSrcB == 0 ? 16'd0 : m_rf[InSrcB];
            haz = 0;
`ifdef FORWARD_EN
            if (WrEn && WrAddr != 0 && WrAddr == InSrcA) ra = WrData;
            if (WrEn && WrAddr != 0 && WrAddr == InSrcB) rb = WrData;
`else
            haz = WrEn && WrAddr != 0 && (WrAddr == InSrcA || (!InUseImm && WrAddr == InSrcB));
`endif
            rdy = !Flush && !haz && (!m_v || OutReady);
            acc = InValid && rdy;
            #1;
            checks++; if (InReady !== rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, InReady, rdy); end
            if (acc) begin m_a = ra; m_b = InUseImm ? InImm : rb; m_op = InOp; end
            m_v = acc || (m_v && !OutReady && !Flush);
            if (WrEn && WrAddr != 0) m_rf[WrAddr] = WrData;
            tick();
            checks++; if (OutValid !== m_v) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, OutValid, m_v); end
            if (m_v) begin
                checks++; if ({InputA, InputB, OP} !== {m_a, m_b, m_op}) begin errors++; $display("FAIL rnd_data[%0d] got %h/%h/%h exp %h/%h/%h", n, InputA, InputB, OP, m_a, m_b, m_op); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_hold();
        test_raw();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
